johnson_seq_ctrl: RTL and testbench

Sequencer for the team's WIDTH-stage Johnson counter, used as a 2·WIDTH-phase timing generator. It accepts a run request carrying a step count and a direction, then advances the twisted-ring state one phase per enabled cycle. It supports hold, abort and homing, and reports completion. It replaces free-running Johnson counters wherever downstream logic needs a bounded, reversible, pausable phase sequence.

---
 rtl/johnson_seq_ctrl_if.sv | 31 +++
 rtl/johnson_seq_ctrl.sv | 89 ++++++++
 tb/tb_johnson_seq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Request/status bundle for the Johnson-ring sequencer.
// Handshake: a run request (start + steps + dir) is taken on a rising clk edge only while ready=1; no queueing.
interface johnson_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
);
  logic             start;
  logic [CNT_W-1:0] steps;
  logic             dir;
  logic             hold;
  logic             abort;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic [IDX_W-1:0] phase_idx;
  logic             busy;
  logic             ready;
  logic             done;
  logic             aborted;
  logic             run_state;

  modport master (
    output start, steps, dir, hold, abort, clear,
    input  q, phase_idx, busy, ready, done, aborted, run_state
  );

  modport slave (
    input  start, steps, dir, hold, abort, clear,
    output q, phase_idx, busy, ready, done, aborted, run_state
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Bounded, reversible, pausable sequencer for a WIDTH-stage Johnson ring.
// Two-state FSM (IDLE/RUN); run_state exposes the FSM state for observation.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input logic               clk,
  input logic               reset,
  johnson_seq_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PW = IDX_W + 1;
  localparam logic [IDX_W:0] RING = PW'(2 * WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] rem;
  logic             dir_r;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] q_fwd;
  logic [WIDTH-1:0] q_rev;
  logic [IDX_W:0]   pop;
  logic [IDX_W:0]   idx_full;

  assign q_fwd = {q[WIDTH-2:0], ~q[WIDTH-1]};
  assign q_rev = {~q[0], q[WIDTH-1:1]};

  // Once the MSB is set the ring is in its second half, counting ones downward.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(q[i]);
    idx_full = q[WIDTH-1] ? (RING - pop) : pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      rem     <= '0;
      dir_r   <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            q <= '0;
          end else if (bus.start) begin
            if (bus.steps != '0) begin
              rem   <= bus.steps;
              dir_r <= bus.dir;
              state <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort outranks even the final step: q stays put and done is withheld.
          if (bus.abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (!bus.hold) begin
            q   <= dir_r ? q_rev : q_fwd;
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q         = q;
  assign bus.phase_idx = idx_full[IDX_W-1:0];
  assign bus.busy      = (state == RUN);
  assign bus.ready     = (state != RUN);
  assign bus.done      = done;
  assign bus.aborted   = aborted;
  assign bus.run_state = state;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed vector table, reset corner, then random stimulus against a phase-count model.
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int IW = 3;
  localparam int NPH = 2 * W;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  johnson_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW), .IDX_W(IW)) bus ();

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [CW-1:0] steps;
    logic          dir;
    logic          hold;
    logic          abort;
    logic          clear;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;
    logic          aborted;
  } vec_t;

  vec_t tbl[$];

  // Ring value for phase p: p ones from the bottom, then the ones drain out from the bottom.
  function automatic int q_of(input int p);
    if (p < W) return (1 << p) - 1;
    return ((1 << W) - 1) - ((1 << (p - W)) - 1);
  endfunction

  function automatic int phase_of(input int qv);
    for (int p = 0; p < NPH; p++) if (q_of(p) == qv) return p;
    return -1;
  endfunction

  function automatic vec_t mk(input int st, input int n, input int d, input int h, input int a,
                              input int c, input int qq, input int b, input int dn, input int ab);
    vec_t v;
    v.start = (st != 0); v.steps = CW'(n); v.dir = (d != 0); v.hold = (h != 0);
    v.abort = (a != 0); v.clear = (c != 0); v.q = W'(qq); v.busy = (b != 0);
    v.done = (dn != 0); v.aborted = (ab != 0);
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int eb, input int ed, input int ea);
    chk({tag, " q"}, int'(bus.q), eq);
    chk({tag, " phase_idx"}, int'(bus.phase_idx), phase_of(eq));
    chk({tag, " busy"}, int'(bus.busy), eb);
    chk({tag, " ready"}, int'(bus.ready), 1 - eb);
    chk({tag, " run_state"}, int'(bus.run_state), eb);
    chk({tag, " done"}, int'(bus.done), ed);
    chk({tag, " aborted"}, int'(bus.aborted), ea);
  endtask

  task automatic drive(input logic st, input logic [CW-1:0] n, input logic d, input logic h,
                       input logic a, input logic c);
    bus.start = st; bus.steps = n; bus.dir = d; bus.hold = h; bus.abort = a; bus.clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: position on the ring as an integer phase, run length as a plain counter.
  int mp, mrem;
  bit mbusy, mdir, mdone, mab;

  task automatic model_reset();
    mp = 0; mrem = 0; mbusy = 0; mdir = 0; mdone = 0; mab = 0;
  endtask

  task automatic model_step(input bit st, input int n, input bit d, input bit h, input bit a, input bit c);
    mdone = 0; mab = 0;
    if (!mbusy) begin
      if (c) mp = 0;
      else if (st) begin
        if (n != 0) begin mrem = n; mdir = d; mbusy = 1; end
        else mdone = 1;
      end
    end else if (a) begin
      mbusy = 0; mab = 1;
    end else if (!h) begin
      mp = mdir ? (mp + NPH - 1) % NPH : (mp + 1) % NPH;
      mrem--;
      if (mrem == 0) begin mbusy = 0; mdone = 1; end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("post_reset", 0, 0, 0, 0);

    // start, steps, dir, hold, abort, clear | q, busy, done, aborted (after the edge)
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 10, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1110, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0011, 0, 1, 0));
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 'b0011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1000, 0, 1, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 'b1000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 0, 1, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 'b0111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 'b1111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1111, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 'b1111, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1111, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 'b1111, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b1110, 0, 1, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 1, 'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 'b0011, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].steps, tbl[i].dir, tbl[i].hold, tbl[i].abort, tbl[i].clear);
      tick();
      check_all($sformatf("vec%0d", i), int'(tbl[i].q), int'(tbl[i].busy),
                int'(tbl[i].done), int'(tbl[i].aborted));
    end

    // Reset mid-run: start 8 steps from 0111, advance 3 times (rem=5), then reset for 3 cycles.
    drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check_all("pre_reset_run", 'b1100, 1, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset_mid_run", 0, 0, 0, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("after_reset_quiet", 0, 0, 0, 0);
    end

    // Random stimulus against the phase model; starts from the reset state just checked.
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit st, d, h, a, c, r;
      int n;
      st = ($urandom_range(0, 99) < 40);
      n  = ($urandom_range(0, 9) == 0) ? 0 :
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 40)) : int'($urandom_range(1, 12));
      d  = 1'($urandom_range(0, 1));
      h  = ($urandom_range(0, 99) < 20);
      a  = ($urandom_range(0, 99) < 5);
      c  = ($urandom_range(0, 99) < 10);
      r  = ($urandom_range(0, 199) == 0);
      reset = r;
      drive(st, CW'(n), d, h, a, c);
      if (r) model_reset();
      else model_step(st, n, d, h, a, c);
      tick();
      check_all("rand", q_of(mp), int'(mbusy), int'(mdone), int'(mab));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
